// File: rtl/race_referee_if.sv
// Pixel stream, car position, key input and HUD/renderer outputs of the race referee.
// The master side is the renderer/sync/HUD environment; the slave side is the referee.
interface race_referee_if;
  logic        p_tick;
  logic        refresh_tick;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        road_on;
  logic        finish_line;
  logic [9:0]  car_x;
  logic        start_key;
  logic        pause;
  logic [2:0]  game_state;
  logic [1:0]  lives;
  logic [15:0] score;
  logic        crash_flash;

  modport master (
    output p_tick, refresh_tick, video_on, pixel_x, pixel_y, road_on, finish_line, car_x,
           start_key,
    input  pause, game_state, lives, score, crash_flash
  );

  modport slave (
    input  p_tick, refresh_tick, video_on, pixel_x, pixel_y, road_on, finish_line, car_x,
           start_key,
    output pause, game_state, lives, score, crash_flash
  );
endinterface

// File: rtl/race_referee.sv
// Race referee: per-frame collision/finish checks against the car footprint and the
// idle/run/crash/over/win game state machine feeding the renderer pause and the HUD.
module race_referee #(
  parameter int unsigned CAR_W        = 32,
  parameter int unsigned CAR_H        = 48,
  parameter int unsigned CAR_Y        = 400,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned MIN_OFF_PIX  = 16,
  parameter int unsigned CRASH_FRAMES = 60
) (
  input logic           clk,
  input logic           reset,
  race_referee_if.slave bus
);

  // Timer is at least 4 bits wide so timer_q[3] always exists for the blink.
  localparam int unsigned TimerW =
      ($clog2(CRASH_FRAMES + 1) > 4) ? $clog2(CRASH_FRAMES + 1) : 4;

  localparam logic [10:0]       FpTop     = 11'(CAR_Y);
  localparam logic [10:0]       FpBot     = 11'(CAR_Y + CAR_H);
  localparam logic [10:0]       FpWidth   = 11'(CAR_W);
  localparam logic [11:0]       OffLimit  = 12'(MIN_OFF_PIX);
  localparam logic [1:0]        LivesInit = 2'(LIVES);
  localparam logic [TimerW-1:0] TimerInit = TimerW'(CRASH_FRAMES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StCrash = 3'd2,
    StOver  = 3'd3,
    StWin   = 3'd4
  } state_e;

  state_e            state_q;
  logic [1:0]        lives_q;
  logic [15:0]       score_q;
  logic [TimerW-1:0] timer_q;
  logic [11:0]       off_cnt_q;
  logic              finish_seen_q;
  logic [9:0]        car_x_q;
  logic              start_key_q;

  logic        start_go;
  logic        in_fp;
  logic        pix_hit;
  logic        off_hit;
  logic        crash_hit;
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] fp_left;
  logic [10:0] fp_right;

  // 11-bit compare so a car near the right edge never wraps its footprint to column 0.
  always_comb begin
    px       = {1'b0, bus.pixel_x};
    py       = {1'b0, bus.pixel_y};
    fp_left  = {1'b0, car_x_q};
    fp_right = fp_left + FpWidth;
    in_fp    = (px >= fp_left) && (px < fp_right) && (py >= FpTop) && (py < FpBot);
  end

  assign start_go  = bus.start_key & ~start_key_q;
  assign pix_hit   = bus.p_tick & bus.video_on & in_fp;
  assign off_hit   = pix_hit & ~bus.road_on & (state_q == StRun);
  assign crash_hit = (off_cnt_q >= OffLimit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_key_q <= 1'b0;
      car_x_q     <= '0;
    end else begin
      start_key_q <= bus.start_key;
      if (bus.refresh_tick) begin
        car_x_q <= bus.car_x;
      end
    end
  end

  // Frame accumulators; the frame-end clear wins over a coincident pixel event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_cnt_q     <= '0;
      finish_seen_q <= 1'b0;
    end else if (bus.refresh_tick) begin
      off_cnt_q     <= '0;
      finish_seen_q <= 1'b0;
    end else begin
      if (off_hit && (off_cnt_q != 12'hFFF)) begin
        off_cnt_q <= off_cnt_q + 12'd1;
      end
      if (pix_hit && bus.finish_line) begin
        finish_seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lives_q <= LivesInit;
      score_q <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_go) begin
            state_q <= StRun;
            lives_q <= LivesInit;
            score_q <= '0;
          end
        end
        StRun: begin
          if (bus.refresh_tick) begin
            if (finish_seen_q) begin
              state_q <= StWin;
            end else if (crash_hit && (lives_q <= 2'd1)) begin
              lives_q <= 2'd0;
              state_q <= StOver;
            end else if (crash_hit) begin
              lives_q <= lives_q - 2'd1;
              timer_q <= TimerInit;
              state_q <= StCrash;
            end else if (score_q != 16'hFFFF) begin
              score_q <= score_q + 16'd1;
            end
          end
        end
        StCrash: begin
          if (bus.refresh_tick) begin
            if (timer_q <= TimerW'(1)) begin
              timer_q <= '0;
              state_q <= StRun;
            end else begin
              timer_q <= timer_q - TimerW'(1);
            end
          end
        end
        StOver, StWin: begin
          if (start_go) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pause       = (state_q != StRun);
  assign bus.game_state  = state_q;
  assign bus.lives       = lives_q;
  assign bus.score       = score_q;
  assign bus.crash_flash = (state_q == StCrash) & timer_q[3];

endmodule

// File: tb/tb_race_referee.sv
// Self-checking bench for race_referee: boundary vector table, hand-written multi-cycle
// sequences, and randomized frames checked against a frame-level reference model.
module tb_race_referee;
  localparam int CAR_W        = 32;
  localparam int CAR_H        = 48;
  localparam int CAR_Y        = 400;
  localparam int LIVES        = 3;
  localparam int MIN_OFF      = 16;
  localparam int CRASH_FRAMES = 60;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  race_referee_if bus ();

  race_referee #(
    .CAR_W       (CAR_W),
    .CAR_H       (CAR_H),
    .CAR_Y       (CAR_Y),
    .LIVES       (LIVES),
    .MIN_OFF_PIX (MIN_OFF),
    .CRASH_FRAMES(CRASH_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cx;
    int px;
    int py;
    int n_off;
    bit fin;
    int exp_state;
    int exp_lives;
  } vec_t;

  // Frame-level reference model state.
  int m_state, m_lives, m_score, m_timer, m_carx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int st, input int lv, input int sc,
                               input int fl);
    check({tag, ".state"}, 32'(bus.game_state), st);
    check({tag, ".pause"}, 32'(bus.pause), (st != 1) ? 1 : 0);
    check({tag, ".lives"}, 32'(bus.lives), lv);
    check({tag, ".score"}, 32'(bus.score), sc);
    check({tag, ".flash"}, 32'(bus.crash_flash), fl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p_tick       = 1'b0;
    bus.refresh_tick = 1'b0;
    bus.video_on     = 1'b1;
    bus.road_on      = 1'b1;
    bus.finish_line  = 1'b0;
    bus.pixel_x      = '0;
    bus.pixel_y      = '0;
  endtask

  task automatic pix(input int x, input int y, input bit road, input bit fin,
                     input bit pt = 1'b1, input bit vo = 1'b1);
    bus.pixel_x     = 10'(x);
    bus.pixel_y     = 10'(y);
    bus.road_on     = road;
    bus.finish_line = fin;
    bus.p_tick      = pt;
    bus.video_on    = vo;
    tick();
    idle_inputs();
  endtask

  task automatic off_pixels(input int n, input int x, input int y);
    for (int i = 0; i < n; i++) pix(x, y, 1'b0, 1'b0);
  endtask

  task automatic frame_end(input int cx);
    bus.car_x        = 10'(cx);
    bus.refresh_tick = 1'b1;
    tick();
    bus.refresh_tick = 1'b0;
  endtask

  task automatic press();
    bus.start_key = 1'b1;
    tick();
    bus.start_key = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    bus.start_key = 1'b0;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  function automatic bit model_in_fp(input int x, input int y);
    return (x >= m_carx) && (x < m_carx + CAR_W) && (y >= CAR_Y) && (y < CAR_Y + CAR_H);
  endfunction

  task automatic model_press();
    if (m_state == 0) begin
      m_state = 1;
      m_lives = LIVES;
      m_score = 0;
    end else if (m_state == 3 || m_state == 4) begin
      m_state = 0;
    end
  endtask

  task automatic model_frame(input int off, input bit fin, input int new_cx);
    if (m_state == 1) begin
      if (fin) m_state = 4;
      else if (off >= MIN_OFF && m_lives == 1) begin
        m_lives = 0;
        m_state = 3;
      end else if (off >= MIN_OFF) begin
        m_lives = m_lives - 1;
        m_timer = CRASH_FRAMES;
        m_state = 2;
      end else if (m_score < 65535) m_score = m_score + 1;
    end else if (m_state == 2) begin
      m_timer = m_timer - 1;
      if (m_timer == 0) m_state = 1;
    end
    m_carx = new_cx;
  endtask

  function automatic int model_flash();
    return (m_state == 2) ? ((m_timer / 8) % 2) : 0;
  endfunction

  initial begin
    vec_t vecs[13];
    vecs[0]  = '{200, 200, 400, 16, 1'b0, 2, 2};
    vecs[1]  = '{200, 231, 447, 16, 1'b0, 2, 2};
    vecs[2]  = '{200, 232, 420, 16, 1'b0, 1, 3};
    vecs[3]  = '{200, 199, 420, 16, 1'b0, 1, 3};
    vecs[4]  = '{200, 210, 399, 16, 1'b0, 1, 3};
    vecs[5]  = '{200, 210, 448, 16, 1'b0, 1, 3};
    vecs[6]  = '{200, 210, 420, 15, 1'b0, 1, 3};
    vecs[7]  = '{200, 210, 420, 100, 1'b1, 4, 3};
    vecs[8]  = '{200, 232, 420, 0, 1'b1, 1, 3};
    vecs[9]  = '{200, 231, 447, 0, 1'b1, 4, 3};
    vecs[10] = '{1000, 1020, 420, 16, 1'b0, 2, 2};
    vecs[11] = '{1000, 5, 420, 16, 1'b0, 1, 3};
    vecs[12] = '{1000, 1023, 447, 16, 1'b0, 2, 2};

    reset         = 1'b1;
    bus.start_key = 1'b0;
    bus.car_x     = '0;
    idle_inputs();
    tick();
    tick();
    check_outputs("reset", 0, 3, 0, 0);
    reset = 1'b0;
    tick();

    // Five clean frames.
    press();
    check_outputs("start", 1, 3, 0, 0);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 3; i++) pix(210, 420, 1'b1, 1'b0);
      frame_end(200);
    end
    check_outputs("five_frames", 1, 3, 5, 0);

    // Threshold: 15 survives, 16 crashes.
    off_pixels(15, 210, 420);
    frame_end(200);
    check_outputs("off15", 1, 3, 6, 0);
    off_pixels(16, 210, 420);
    frame_end(200);
    check_outputs("off16", 2, 2, 6, 1);

    // Crash lasts exactly CRASH_FRAMES frames; off-road pixels are ignored meanwhile.
    for (int k = 1; k <= CRASH_FRAMES; k++) begin
      off_pixels(20, 210, 420);
      frame_end(200);
      check_outputs($sformatf("crash_f%0d", k), (k == CRASH_FRAMES) ? 1 : 2, 2, 6,
                    (k == CRASH_FRAMES) ? 0 : (((CRASH_FRAMES - k) / 8) % 2));
    end

    // Down to game over, then two presses to restart.
    off_pixels(16, 210, 420);
    frame_end(200);
    check_outputs("crash2", 2, 1, 6, 1);
    for (int k = 0; k < CRASH_FRAMES; k++) frame_end(200);
    check_outputs("crash2_done", 1, 1, 6, 0);
    off_pixels(16, 210, 420);
    frame_end(200);
    check_outputs("over", 3, 0, 6, 0);
    frame_end(200);
    check_outputs("over_hold", 3, 0, 6, 0);
    press();
    check_outputs("over_to_idle", 0, 0, 6, 0);
    press();
    check_outputs("idle_to_run", 1, 3, 0, 0);

    // Pixel event coincident with refresh_tick is dropped by the clear.
    off_pixels(15, 210, 420);
    bus.pixel_x      = 10'd210;
    bus.pixel_y      = 10'd420;
    bus.road_on      = 1'b0;
    bus.p_tick       = 1'b1;
    bus.car_x        = 10'd200;
    bus.refresh_tick = 1'b1;
    tick();
    idle_inputs();
    check_outputs("coincide_frame", 1, 3, 1, 0);
    off_pixels(15, 210, 420);
    frame_end(200);
    check_outputs("clear_wins", 1, 3, 2, 0);

    // start ignored in RUN; win; start beats a coincident refresh.
    press();
    check_outputs("start_in_run", 1, 3, 2, 0);
    pix(210, 420, 1'b1, 1'b1);
    frame_end(200);
    check_outputs("win", 4, 3, 2, 0);
    bus.start_key    = 1'b1;
    bus.refresh_tick = 1'b1;
    tick();
    bus.start_key    = 1'b0;
    bus.refresh_tick = 1'b0;
    tick();
    check_outputs("win_start_refresh", 0, 3, 2, 0);
    frame_end(200);
    check_outputs("idle_refresh", 0, 3, 2, 0);

    // off_cnt saturates rather than wrapping to zero.
    press();
    check_outputs("sat_start", 1, 3, 0, 0);
    off_pixels(4096, 210, 420);
    frame_end(200);
    check_outputs("sat4096", 2, 2, 0, 1);

    // Asynchronous reset between clock edges, mid-crash.
    off_pixels(5, 210, 420);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 0, 3, 0, 0);
    #2;
    reset = 1'b0;
    tick();
    check_outputs("after_reset", 0, 3, 0, 0);
    press();
    frame_end(200);
    check_outputs("restart_after_reset", 1, 3, 1, 0);

    // Boundary vector table.
    foreach (vecs[v]) begin
      do_reset();
      press();
      frame_end(vecs[v].cx);
      for (int i = 0; i < vecs[v].n_off; i++) pix(vecs[v].px, vecs[v].py, 1'b0, vecs[v].fin);
      if (vecs[v].n_off == 0 && vecs[v].fin) pix(vecs[v].px, vecs[v].py, 1'b1, 1'b1);
      frame_end(vecs[v].cx);
      check($sformatf("vec%0d.state", v), 32'(bus.game_state), vecs[v].exp_state);
      check($sformatf("vec%0d.lives", v), 32'(bus.lives), vecs[v].exp_lives);
      check($sformatf("vec%0d.score", v), 32'(bus.score), (vecs[v].exp_state == 1) ? 2 : 1);
    end

    // Randomized frames against the reference model.
    do_reset();
    m_state = 0;
    m_lives = LIVES;
    m_score = 0;
    m_timer = 0;
    m_carx  = 0;
    for (int f = 0; f < 400; f++) begin
      int n, off, new_cx;
      bit fin;
      if ($urandom_range(0, 3) == 0) begin
        press();
        model_press();
        check_outputs($sformatf("rnd_press%0d", f), m_state, m_lives, m_score, model_flash());
      end
      n   = $urandom_range(0, 24);
      off = 0;
      fin = 1'b0;
      for (int i = 0; i < n; i++) begin
        int x, y;
        bit road, fl, pt, vo;
        x    = ($urandom_range(0, 2) != 0) ? m_carx + $urandom_range(0, CAR_W - 1)
                                           : m_carx + CAR_W + $urandom_range(0, 50);
        y    = ($urandom_range(0, 3) != 0) ? CAR_Y + $urandom_range(0, CAR_H - 1)
                                           : $urandom_range(0, CAR_Y - 1);
        road = 1'($urandom_range(0, 1));
        fl   = ($urandom_range(0, 40) == 0);
        pt   = ($urandom_range(0, 7) != 0);
        vo   = ($urandom_range(0, 7) != 0);
        pix(x, y, road, fl, pt, vo);
        if (pt && vo && model_in_fp(x, y)) begin
          if (!road && m_state == 1) off++;
          if (fl) fin = 1'b1;
        end
      end
      new_cx = $urandom_range(0, 900);
      frame_end(new_cx);
      model_frame(off, fin, new_cx);
      check_outputs($sformatf("rnd_frame%0d", f), m_state, m_lives, m_score, model_flash());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
